// File: rtl/fir_dac_tx.sv
// fir_dac_tx: captures one filter sample per sample-rate strobe and shifts it out
// to a 16-bit serial DAC as {CMD, offset-binary sample}, MSB first.
module fir_dac_tx #(
  parameter int         CLK_DIV = 2,
  parameter logic [3:0] CMD     = 4'b0011
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        f_s,
  input  logic [11:0] din,
  output logic        dac_cs_n,
  output logic        dac_sclk,
  output logic        dac_sdo,
  output logic        busy,
  output logic        ovr
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);

  state_t      state, state_nx;
  logic        p0, p1, cap;
  logic        req;
  logic [7:0]  hcnt, hcnt_nx;
  logic [4:0]  bcnt, bcnt_nx;
  logic [15:0] sreg, sreg_nx;
  logic        sclk, sclk_nx;
  logic        ovr_q, ovr_nx;

  assign req = p0 & ~p1;

  // Capture lags the request by one clk so din is taken after the filter has settled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p0  <= 1'b0;
      p1  <= 1'b0;
      cap <= 1'b0;
    end else begin
      p0  <= f_s;
      p1  <= p0;
      cap <= req;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      hcnt  <= '0;
      bcnt  <= '0;
      sreg  <= '0;
      sclk  <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      state <= state_nx;
      hcnt  <= hcnt_nx;
      bcnt  <= bcnt_nx;
      sreg  <= sreg_nx;
      sclk  <= sclk_nx;
      ovr_q <= ovr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    hcnt_nx  = hcnt;
    bcnt_nx  = bcnt;
    sreg_nx  = sreg;
    sclk_nx  = sclk;
    ovr_nx   = ovr_q;

    // A capture outside IDLE (GAP included) is lost; the running frame is untouched.
    if (cap && (state != IDLE)) ovr_nx = 1'b1;

    case (state)
      IDLE: begin
        if (cap) begin
          state_nx = SHIFT;
          sreg_nx  = {CMD, din ^ 12'h800};
          hcnt_nx  = '0;
          bcnt_nx  = '0;
          sclk_nx  = 1'b0;
        end
      end
      SHIFT: begin
        if (hcnt == HALF_LAST) begin
          hcnt_nx = '0;
          if (!sclk) begin
            sclk_nx = 1'b1;
          end else begin
            sclk_nx = 1'b0;
            bcnt_nx = bcnt + 5'd1;
            if (bcnt == 5'd15) state_nx = GAP;
            else               sreg_nx  = {sreg[14:0], 1'b0};
          end
        end else begin
          hcnt_nx = hcnt + 8'd1;
        end
      end
      GAP: begin
        if (hcnt == HALF_LAST) begin
          state_nx = IDLE;
          hcnt_nx  = '0;
          bcnt_nx  = '0;
          sreg_nx  = '0;
        end else begin
          hcnt_nx = hcnt + 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign dac_cs_n = (state != SHIFT);
  assign dac_sclk = sclk;
  assign dac_sdo  = (state == SHIFT) && sreg[15];
  assign busy     = (state != IDLE);
  assign ovr      = ovr_q;

endmodule

// File: tb/tb_fir_dac_tx.sv
// tb_fir_dac_tx: drives fir_dac_tx at CLK_DIV 2 and 1 side by side and compares them
// against a timeline model built from the frame timing rules.
module tb_fir_dac_tx;

  typedef struct {
    logic [11:0] din;
    logic [15:0] word;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        f_s = 1'b0;
  logic [11:0] din = '0;
  logic        cs_n2, sclk2, sdo2, busy2, ovr2;
  logic        cs_n1, sclk1, sdo1, busy1, ovr1;
  int          compared = 0;
  int          mismatched = 0;
  bit          check_en = 1'b0;

  always #5 clk = ~clk;

  fir_dac_tx #(.CLK_DIV(2), .CMD(4'b0011)) dut2 (
    .rst(rst), .clk(clk), .f_s(f_s), .din(din),
    .dac_cs_n(cs_n2), .dac_sclk(sclk2), .dac_sdo(sdo2), .busy(busy2), .ovr(ovr2)
  );

  fir_dac_tx #(.CLK_DIV(1), .CMD(4'b0011)) dut1 (
    .rst(rst), .clk(clk), .f_s(f_s), .din(din),
    .dac_cs_n(cs_n1), .dac_sclk(sclk1), .dac_sdo(sdo1), .busy(busy1), .ovr(ovr1)
  );

  // Reference: each instance remembers the clk index of its last accepted capture
  // and its frame word; outputs follow from the elapsed clk count.
  int          n_m = 0;
  int          t0_m [2] = '{-100000, -100000};
  logic [15:0] word_m [2] = '{16'h0, 16'h0};
  logic        ovr_m [2] = '{1'b0, 1'b0};
  logic        prev_fs = 1'b0;
  int          cap_q [$];

  function automatic int divOf(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      cap_q.delete();
      prev_fs = 1'b0;
      for (int i = 0; i < 2; i++) begin
        t0_m[i]   = -100000;
        word_m[i] = '0;
        ovr_m[i]  = 1'b0;
      end
    end else begin
      n_m++;
      while (cap_q.size() > 0 && cap_q[0] == n_m) begin
        void'(cap_q.pop_front());
        for (int i = 0; i < 2; i++) begin
          if (n_m - t0_m[i] > 33 * divOf(i)) begin
            t0_m[i]   = n_m;
            word_m[i] = {4'b0011, din ^ 12'h800};
          end else begin
            ovr_m[i] = 1'b1;
          end
        end
      end
      if (f_s && !prev_fs) cap_q.push_back(n_m + 2);
      prev_fs = f_s;
    end
  end

  function automatic logic [4:0] expOut(input int i);
    int   dv, d, idx;
    logic cs, sc, sd, bz;
    dv = divOf(i);
    d  = n_m - t0_m[i];
    bz = (d < 33 * dv);
    cs = !(d < 32 * dv);
    sc = (d < 32 * dv) && (((d / dv) % 2) == 1);
    sd = 1'b0;
    if (d < 32 * dv) begin
      idx = 15 - d / (2 * dv);
      sd  = word_m[i][idx];
    end
    return {cs, sc, sd, bz, ovr_m[i]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [11:0] d, input logic fs);
    din = d;
    f_s = fs;
  endtask

  task automatic pulseFs(input logic [11:0] d, input int delay);
    repeat (delay) @(negedge clk);
    applyStimulus(d, 1'b1);
    repeat (3) @(negedge clk);
    applyStimulus(d, 1'b0);
  endtask

  task automatic collectFrame(output logic [15:0] word, output int rises,
                              output int cs_low, output int busy_len);
    int   guard;
    logic prev;
    guard = 0;
    prev = 1'b0;
    word = '0;
    rises = 0;
    cs_low = 0;
    busy_len = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!busy2 && guard < 200);
    checkOutput("frame_start", 32'(busy2), 32'd1);
    guard = 0;
    while (busy2 && guard < 300) begin
      if (!cs_n2) cs_low++;
      busy_len++;
      if (sclk2 && !prev) begin
        word = {word[14:0], sdo2};
        rises++;
      end
      prev = sclk2;
      guard++;
      @(negedge clk);
    end
  endtask

  task automatic checkFrame(input string tag, input logic [15:0] w, input int r,
                            input int c, input int b, input logic [15:0] expw);
    checkOutput({tag, "_word"}, 32'(w), 32'(expw));
    checkOutput({tag, "_sclk_rises"}, r, 16);
    checkOutput({tag, "_cs_low_clks"}, c, 64);
    checkOutput({tag, "_busy_clks"}, b, 66);
  endtask

  task automatic doReset();
    #2;
    rst = 1'b0;
    #1;
    checkOutput("reset_div2", 32'({cs_n2, sclk2, sdo2, busy2, ovr2}), 32'h10);
    checkOutput("reset_div1", 32'({cs_n1, sclk1, sdo1, busy1, ovr1}), 32'h10);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
  endtask

  initial forever begin
    @(negedge clk);
    if (check_en) begin
      checkOutput("cycle_div2", 32'({cs_n2, sclk2, sdo2, busy2, ovr2}), 32'(expOut(0)));
      checkOutput("cycle_div1", 32'({cs_n1, sclk1, sdo1, busy1, ovr1}), 32'(expOut(1)));
    end
  end

  initial begin
    #1000000;
    mismatched++;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    vec_t        vecs [5];
    logic [15:0] w, w2;
    int          r, c, b, r2, c2, b2;
    int          cnt, bcount, wid, gap, busyc, frames, unstable;
    logic        prev, pb, ps, psdo;

    vecs[0] = '{din: 12'h000, word: 16'h3800};
    vecs[1] = '{din: 12'h800, word: 16'h3000};
    vecs[2] = '{din: 12'h7FF, word: 16'h3FFF};
    vecs[3] = '{din: 12'h123, word: 16'h3923};
    vecs[4] = '{din: 12'hFFF, word: 16'h37FF};

    applyStimulus(12'h000, 1'b0);
    repeat (4) @(negedge clk);
    #1;
    checkOutput("reset_div2", 32'({cs_n2, sclk2, sdo2, busy2, ovr2}), 32'h10);
    checkOutput("reset_div1", 32'({cs_n1, sclk1, sdo1, busy1, ovr1}), 32'h10);
    @(negedge clk);
    #2;
    rst = 1'b1;
    check_en = 1'b1;

    // Single frames, including the two extreme codes back to back.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      fork
        pulseFs(vecs[k].din, 0);
        collectFrame(w, r, c, b);
      join
      checkFrame($sformatf("vec%0d", k), w, r, c, b, vecs[k].word);
      checkOutput($sformatf("vec%0d_ovr", k), 32'(ovr2), 32'd0);
      repeat (3) @(negedge clk);
    end

    // Second request 20 clk into a frame is dropped and flagged.
    @(negedge clk);
    fork
      begin
        pulseFs(12'h456, 0);
        pulseFs(12'h111, 17);
      end
      collectFrame(w, r, c, b);
    join
    checkFrame("overrun_first", w, r, c, b, 16'h3C56);
    checkOutput("ovr_set", 32'(ovr2), 32'd1);
    repeat (3) @(negedge clk);
    fork
      pulseFs(12'h222, 0);
      collectFrame(w, r, c, b);
    join
    checkFrame("after_ovr", w, r, c, b, 16'h3A22);
    checkOutput("ovr_sticky", 32'(ovr2), 32'd1);

    // Reset right after the 8th SCLK rising edge.
    repeat (3) @(negedge clk);
    cnt = 0;
    prev = 1'b0;
    fork
      pulseFs(12'h3C3, 0);
      begin
        for (int g = 0; g < 400 && cnt < 8; g++) begin
          @(negedge clk);
          if (sclk2 && !prev) cnt++;
          prev = sclk2;
        end
      end
    join
    checkOutput("rise8_reached", cnt, 8);
    doReset();
    cnt = 0;
    bcount = 0;
    prev = 1'b0;
    for (int g = 0; g < 10; g++) begin
      @(negedge clk);
      if (sclk2 && !prev) cnt++;
      if (busy2) bcount++;
      prev = sclk2;
    end
    checkOutput("no_sclk_after_abort", cnt, 0);
    checkOutput("no_busy_after_abort", bcount, 0);
    fork
      pulseFs(12'h0F0, 0);
      collectFrame(w, r, c, b);
    join
    checkFrame("post_reset", w, r, c, b, 16'h38F0);
    checkOutput("post_reset_ovr", 32'(ovr2), 32'd0);

    // Capture landing exactly on GAP->IDLE is dropped; one clk later it is taken.
    repeat (3) @(negedge clk);
    fork
      begin
        pulseFs(12'h001, 0);
        pulseFs(12'hABC, 63);
      end
      collectFrame(w, r, c, b);
    join
    checkFrame("edge_first", w, r, c, b, 16'h3801);
    bcount = 0;
    for (int g = 0; g < 80; g++) begin
      @(negedge clk);
      if (busy2) bcount++;
    end
    checkOutput("edge_drop_no_frame", bcount, 0);
    checkOutput("edge_drop_ovr", 32'(ovr2), 32'd1);
    @(negedge clk);
    doReset();
    @(negedge clk);
    fork
      begin
        pulseFs(12'h001, 0);
        pulseFs(12'hABC, 64);
      end
      begin
        collectFrame(w, r, c, b);
        collectFrame(w2, r2, c2, b2);
      end
    join
    checkFrame("edge_first_b", w, r, c, b, 16'h3801);
    checkFrame("edge_accept", w2, r2, c2, b2, 16'h32BC);
    checkOutput("edge_accept_ovr", 32'(ovr2), 32'd0);

    // Random requests with din changing every clk; the timeline model checks each cycle.
    repeat (5) @(negedge clk);
    for (int k = 0; k < 30; k++) begin
      wid = $urandom_range(1, 4);
      gap = $urandom_range(1, 90);
      for (int j = 0; j < wid; j++) begin
        applyStimulus(12'($urandom), 1'b1);
        @(negedge clk);
      end
      for (int j = 0; j < gap; j++) begin
        applyStimulus(12'($urandom), 1'b0);
        @(negedge clk);
      end
    end

    // f_s held high: exactly one frame, sdo steady across every SCLK rise.
    repeat (150) @(negedge clk);
    applyStimulus(12'h5A5, 1'b1);
    busyc = 0;
    frames = 0;
    cnt = 0;
    unstable = 0;
    w = '0;
    pb = 1'b0;
    ps = 1'b0;
    psdo = 1'b0;
    for (int j = 0; j < 1000; j++) begin
      @(negedge clk);
      if (busy1) busyc++;
      if (busy1 && !pb) frames++;
      if (sclk1 && !ps) begin
        cnt++;
        w = {w[14:0], sdo1};
        if (sdo1 !== psdo) unstable++;
      end
      pb = busy1;
      ps = sclk1;
      psdo = sdo1;
    end
    applyStimulus(12'h5A5, 1'b0);
    checkOutput("held_busy_clks", busyc, 33);
    checkOutput("held_frames", frames, 1);
    checkOutput("held_sclk_rises", cnt, 16);
    checkOutput("held_sdo_unstable", unstable, 0);
    checkOutput("held_word", 32'(w), 32'h3DA5);

    repeat (10) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
